// File: rtl/branch_flag_unit_if.sv
// rtl/branch_flag_unit_if.sv - execute-stage to branch/flag unit signal bundle
interface branch_flag_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic                en;
    logic                ex_valid;
    logic                alu_carry;
    logic                alu_zero;
    logic                carry_we;
    logic [3:0]          br_type;
    logic [PC_WIDTH-1:0] imm_target;
    logic [PC_WIDTH-1:0] reg_target;
    logic [PC_WIDTH-1:0] pc;
    logic                flush;
    logic                link_we;
    logic [PC_WIDTH-1:0] link_addr;
    logic                carry_flag;
    logic                halted;

    modport master (
        output en, ex_valid, alu_carry, alu_zero, carry_we, br_type, imm_target, reg_target,
        input  pc, flush, link_we, link_addr, carry_flag, halted
    );

    modport slave (
        input  en, ex_valid, alu_carry, alu_zero, carry_we, br_type, imm_target, reg_target,
        output pc, flush, link_we, link_addr, carry_flag, halted
    );
endinterface

// File: rtl/branch_flag_unit.sv
// rtl/branch_flag_unit.sv - carry flag, branch resolution and program counter
module branch_flag_unit #(
    parameter int                    PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0,
    parameter int unsigned           PC_STEP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    branch_flag_unit_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] BR_B    = 4'b0001;
    localparam logic [3:0] BR_BR   = 4'b0010;
    localparam logic [3:0] BR_BLTZ = 4'b0011;
    localparam logic [3:0] BR_BZ   = 4'b0100;
    localparam logic [3:0] BR_BNZ  = 4'b0101;
    localparam logic [3:0] BR_BL   = 4'b0110;
    localparam logic [3:0] BR_BCY  = 4'b0111;
    localparam logic [3:0] BR_BNCY = 4'b1000;
    localparam logic [3:0] BR_HALT = 4'b1001;

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

    state_t              state, state_n;
    logic [PC_WIDTH-1:0] pc_q, pc_n;
    logic [PC_WIDTH-1:0] link_addr_q, link_addr_n;
    logic                carry_q, carry_n;
    logic                flush_q, flush_n;
    logic                link_we_q, link_we_n;
    logic                halted_q, halted_n;
    logic                commit;
    logic                taken;
    logic [PC_WIDTH-1:0] target;
    logic [PC_WIDTH-1:0] pc_seq;

    assign commit = bus.ex_valid && (state == ST_RUN);
    assign pc_seq = pc_q + STEP;

    always_comb begin
        taken  = 1'b0;
        target = bus.imm_target;
        case (bus.br_type)
            BR_B, BR_BL:     taken = 1'b1;
            BR_BR: begin
                taken  = 1'b1;
                target = bus.reg_target;
            end
            BR_BLTZ, BR_BZ:  taken = bus.alu_zero;
            BR_BNZ:          taken = !bus.alu_zero;
            // Conditional-on-carry branches see the flag as it stood before this cycle
            BR_BCY:          taken = carry_q;
            BR_BNCY:         taken = !carry_q;
            default:         taken = 1'b0;
        endcase
    end

    always_comb begin
        state_n     = state;
        pc_n        = pc_q;
        carry_n     = carry_q;
        link_addr_n = link_addr_q;
        flush_n     = 1'b0;
        link_we_n   = 1'b0;
        halted_n    = halted_q;
        case (state)
            ST_RUN: begin
                pc_n = pc_seq;
                if (commit && bus.carry_we) begin
                    carry_n = bus.alu_carry;
                end
                if (commit && bus.br_type == BR_HALT) begin
                    pc_n     = pc_q;
                    halted_n = 1'b1;
                    state_n  = ST_HALT;
                end else if (commit && taken) begin
                    pc_n    = target;
                    flush_n = 1'b1;
                    state_n = ST_FLUSH;
                    if (bus.br_type == BR_BL) begin
                        link_addr_n = pc_seq;
                        link_we_n   = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                pc_n    = pc_seq;
                state_n = ST_RUN;
            end
            default: begin
                state_n = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else if (bus.en) begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            carry_q     <= 1'b0;
            link_addr_q <= '0;
            flush_q     <= 1'b0;
            link_we_q   <= 1'b0;
            halted_q    <= 1'b0;
        end else if (bus.en) begin
            pc_q        <= pc_n;
            carry_q     <= carry_n;
            link_addr_q <= link_addr_n;
            flush_q     <= flush_n;
            link_we_q   <= link_we_n;
            halted_q    <= halted_n;
        end
    end

    // A stall must not squash or write anything; the pulses resume when en returns
    assign bus.flush      = flush_q && bus.en;
    assign bus.link_we    = link_we_q && bus.en;
    assign bus.pc         = pc_q;
    assign bus.link_addr  = link_addr_q;
    assign bus.carry_flag = carry_q;
    assign bus.halted     = halted_q;
endmodule

// File: tb/tb_branch_flag_unit.sv
// tb/tb_branch_flag_unit.sv - directed-vector bench for branch_flag_unit
module tb_branch_flag_unit;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    branch_flag_unit_if #(.PC_WIDTH(32)) bus ();

    branch_flag_unit #(
        .PC_WIDTH(32),
        .RESET_PC(32'h0000_0000),
        .PC_STEP (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ex_valid   = 1'b0;
        bus.carry_we   = 1'b0;
        bus.alu_carry  = 1'b0;
        bus.alu_zero   = 1'b0;
        bus.br_type    = 4'b0000;
        bus.imm_target = '0;
        bus.reg_target = '0;
    endtask

    task automatic issue(input logic [3:0] bt, input logic [31:0] tgt, input logic zero);
        bus.ex_valid   = 1'b1;
        bus.carry_we   = 1'b0;
        bus.br_type    = bt;
        bus.imm_target = tgt;
        bus.alu_zero   = zero;
    endtask

    task automatic check_pc_flush(input string tag, input logic [31:0] epc, input logic efl);
        check({tag, "_pc"}, bus.pc, epc);
        check({tag, "_flush"}, {31'd0, bus.flush}, {31'd0, efl});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.en  = 1'b1;
        idle();
        #12;
        check("rst_pc", bus.pc, 32'h0);
        check("rst_carry", {31'd0, bus.carry_flag}, 32'd0);
        check("rst_flush", {31'd0, bus.flush}, 32'd0);
        check("rst_link_we", {31'd0, bus.link_we}, 32'd0);
        check("rst_link_addr", bus.link_addr, 32'h0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(); check_pc_flush("seq1", 32'd4, 1'b0);
        step(); check_pc_flush("seq2", 32'd8, 1'b0);
        step(); check_pc_flush("seq3", 32'd12, 1'b0);
        check("seq_carry", {31'd0, bus.carry_flag}, 32'd0);

        // add setting carry, then bcy
        bus.ex_valid = 1'b1; bus.carry_we = 1'b1; bus.alu_carry = 1'b1;
        step(); check_pc_flush("add", 32'd16, 1'b0);
        check("add_carry", {31'd0, bus.carry_flag}, 32'd1);
        issue(4'b0111, 32'h40, 1'b0);
        step(); check_pc_flush("bcy", 32'h40, 1'b1);
        idle();
        step(); check_pc_flush("bcy_after", 32'h44, 1'b0);

        issue(4'b0100, 32'h200, 1'b0);
        step(); check_pc_flush("bz_nt", 32'h48, 1'b0);
        issue(4'b0101, 32'h100, 1'b0);
        step(); check_pc_flush("bnz_t", 32'h100, 1'b1);
        idle();
        step(); check_pc_flush("bnz_after", 32'h104, 1'b0);
        issue(4'b1111, 32'h700, 1'b1);
        step(); check_pc_flush("undef_br", 32'h108, 1'b0);

        // get to pc 0x20 then bl
        issue(4'b0001, 32'h1C, 1'b0);
        step(); check_pc_flush("b_1c", 32'h1C, 1'b1);
        idle();
        step(); check_pc_flush("to_20", 32'h20, 1'b0);
        issue(4'b0110, 32'h80, 1'b0);
        step(); check_pc_flush("bl", 32'h80, 1'b1);
        check("bl_link_addr", bus.link_addr, 32'h24);
        check("bl_link_we", {31'd0, bus.link_we}, 32'd1);
        issue(4'b0001, 32'h300, 1'b0);
        step(); check_pc_flush("br_in_flush", 32'h84, 1'b0);
        check("bl_link_we_off", {31'd0, bus.link_we}, 32'd0);
        check("bl_link_hold", bus.link_addr, 32'h24);

        // wrap
        issue(4'b0001, 32'hFFFF_FFF8, 1'b0);
        step(); check_pc_flush("b_fff8", 32'hFFFF_FFF8, 1'b1);
        idle();
        step(); check_pc_flush("fffc", 32'hFFFF_FFFC, 1'b0);
        step(); check_pc_flush("wrap", 32'h0, 1'b0);

        // stall with a taken branch and carry update presented
        bus.en = 1'b0;
        issue(4'b0001, 32'h500, 1'b0);
        bus.carry_we = 1'b1; bus.alu_carry = 1'b0;
        step(); check_pc_flush("stall1", 32'h0, 1'b0);
        step(); check_pc_flush("stall2", 32'h0, 1'b0);
        check("stall_carry", {31'd0, bus.carry_flag}, 32'd1);
        bus.en = 1'b1;
        idle();
        step(); check_pc_flush("unstall", 32'h4, 1'b0);

        issue(4'b1000, 32'h900, 1'b0);
        step(); check_pc_flush("bncy_nt", 32'h8, 1'b0);
        issue(4'b0010, 32'h900, 1'b0);
        bus.reg_target = 32'h600;
        step(); check_pc_flush("br_reg", 32'h600, 1'b1);
        idle();
        step(); check_pc_flush("br_after", 32'h604, 1'b0);

        issue(4'b1001, 32'h0, 1'b0);
        step(); check_pc_flush("halt", 32'h604, 1'b0);
        check("halted", {31'd0, bus.halted}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            issue(4'b0001, 32'h1000 + 32'(i), 1'b0);
            step();
            check_pc_flush("halt_hold", 32'h604, 1'b0);
        end
        check("halt_still", {31'd0, bus.halted}, 32'd1);

        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", bus.pc, 32'h0);
        check("async_rst_halted", {31'd0, bus.halted}, 32'd0);
        check("async_rst_carry", {31'd0, bus.carry_flag}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
